decoder_node_n: RTL and testbench
=================================

Name: decoder_node_n

Overview:
- Clocked, parametrised successor to the two-way parent decoder. Accepts one WIDTH-bit flit per cycle on a valid/ready input and routes it unchanged to one of NUM_OUT output channels.
- Each accepted flit also emits a select token carrying the chosen output index. This lets downstream merge logic and checkers reconstruct ordering.
- Used at every tree level of the NoC. Per-output and select buffering of DEPTH entries decouples backpressure between branches.

Parameters:
- WIDTH, 9, flit width in bits.
- NUM_OUT, 2, number of output channels, 2..16.
- SEL_W, $clog2(NUM_OUT), width of route index and select token (derived; not overridden).
- ROUTE_MODE, 0, 0 = mask mode, 1 = field mode.
  - Mask mode: index = |(in_data & MASK). Legal only when NUM_OUT == 2.
  - Field mode: index = in_data[ROUTE_LSB +: SEL_W].
- MASK, 9'b000001000, routing mask for mask mode.
- ROUTE_LSB, 0, LSB of the route field in field mode.
- DEPTH, 2, entries per output FIFO and in the select FIFO, >= 2, power of 2.

Ports:
- CLK  in  1  clock, rising edge.
- _RESET  in  1  asynchronous active-low reset.
- in_data  in  WIDTH  input flit.
- in_valid  in  1  input flit valid.
- in_ready  out  1  flit accepted this cycle when in_valid && in_ready.
- out_data  out  NUM_OUT*WIDTH  packed output flits; channel k at [k*WIDTH +: WIDTH].
- out_valid  out  NUM_OUT  per-channel valid.
- out_ready  in  NUM_OUT  per-channel ready.
- sel_idx  out  SEL_W  select token (index of the routed output).
- sel_valid  out  1  select token valid.
- sel_ready  in  1  select token consumed.
- err_drop  out  1  one-cycle pulse when a flit is discarded for an illegal index.
- drop_count  out  8  saturating count of dropped flits.

Behaviour:
- Reset (asynchronous, _RESET low):
  - All FIFOs empty; out_valid = 0, sel_valid = 0.
  - err_drop = 0, drop_count = 0; out_data and sel_idx = 0.
  - Reset asserted mid-operation discards all buffered flits and tokens immediately. No partial transfer survives.
- Index computation is combinational from in_data per ROUTE_MODE. idx >= NUM_OUT is illegal; this can only occur in field mode with NUM_OUT not a power of 2.
- in_ready, legal idx: high iff FIFO[idx] not full AND select FIFO not full.
- in_ready, illegal idx: always high. The flit is consumed and dropped, err_drop pulses the next cycle, drop_count increments and saturates at 255, and no select token is written.
- in_ready uses occupancy at cycle start. A pop on a full FIFO in the same cycle does not free space for a push; there is no combinational path from out_ready or sel_ready to in_ready.
- Accept at edge t:
  - Flit written to FIFO[idx] and idx written to the select FIFO.
  - out_valid[idx] and sel_valid visible after edge t, i.e. latency 1 cycle.
- Output handshake: a channel pops when out_valid[k] && out_ready[k]. Channels pop independently; a stalled channel never blocks others except through the shared select FIFO.
- Select handshake: pops when sel_valid && sel_ready. Token order equals flit acceptance order.
- Each FIFO keeps a count of 0..DEPTH with wrap-around pointers.
  - Simultaneous push and pop on a non-full FIFO: count unchanged, data ordering preserved.
  - Pop on an empty FIFO: impossible, since valid is low.
- Throughput: 1 flit/cycle sustained when the target output and select consumer are always ready. Steady-state occupancy is 1.
- Elaboration errors: ROUTE_MODE=0 with NUM_OUT != 2, DEPTH < 2, or DEPTH not a power of 2.

Decomposition:
- Package decoder_pkg:
  - route_mode_e enum (ROUTE_MASK=0, ROUTE_FIELD=1).
  - DROP_CNT_W = 8 constant.
  - sel_width(n) function used for SEL_W.
- Sub-module route_fifo (params W, DEPTH; ports CLK, _RESET, push, push_data, pop, pop_data, full, empty).
  - Instantiated NUM_OUT times with W=WIDTH, and once with W=SEL_W for the select FIFO.
- Top module holds index logic, the drop path/counter and channel packing. Roughly 200-300 lines total.

Test Plan:
1. Mask mode, MASK=9'h008, all readies high: send 9'h008 then 9'h001.
   - 9'h008 on out 1, then 9'h001 on out 0, each 1 cycle after accept.
   - Tokens 1, 0 in order.
2. Field mode, NUM_OUT=4, ROUTE_LSB=0: stream 0x100..0x103 back to back.
   - One flit on each out 0..3, one per cycle.
   - sel_idx sequence 0,1,2,3; in_ready never drops.
3. Backpressure, DEPTH=2: hold out_ready[1]=0, send three flits for out 1.
   - First two accepted; in_ready low for the third until out_ready[1] rises.
   - Flits to out 0 still accepted while the select FIFO has space.
4. Illegal index, NUM_OUT=3, field mode: send flit with idx=3.
   - Accepted in one cycle; no out_valid and no token.
   - err_drop high one cycle; drop_count 0->1.
   - 260 illegal flits saturate drop_count at 255.
5. Reset mid-stream: deassert _RESET asynchronously while 2 flits are buffered.
   - All valids 0 immediately and drop_count 0.
   - After release, the first new flit emerges alone with token order restarted.
6. Full FIFO with same-cycle pop: out 0 FIFO full, out_ready[0]=1, new flit for out 0.
   - in_ready low that cycle, high the next; no flit lost or duplicated.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and constants for the parametrised flit decoder node.
package decoder_pkg;

    typedef enum logic {
        ROUTE_MASK  = 1'b0,
        ROUTE_FIELD = 1'b1
    } route_mode_e;

    localparam int DROP_CNT_W = 8;

    // Route index width; a two-way node still needs one select bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/decoder_node_n_if.sv
// Flit input, routed outputs, select token stream and drop status of one decoder node.
interface decoder_node_n_if
    import decoder_pkg::*;
#(
    parameter int WIDTH   = 9,
    parameter int NUM_OUT = 2,
    parameter int SEL_W   = 1
);

    logic [WIDTH-1:0]         in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_OUT*WIDTH-1:0] out_data;
    logic [NUM_OUT-1:0]       out_valid;
    logic [NUM_OUT-1:0]       out_ready;
    logic [SEL_W-1:0]         sel_idx;
    logic                     sel_valid;
    logic                     sel_ready;
    logic                     err_drop;
    logic [DROP_CNT_W-1:0]    drop_count;

    // The decoder node itself.
    modport slave (
        input  in_data, in_valid, out_ready, sel_ready,
        output in_ready, out_data, out_valid, sel_idx, sel_valid, err_drop, drop_count
    );

    // Upstream producer plus downstream consumers.
    modport master (
        output in_data, in_valid, out_ready, sel_ready,
        input  in_ready, out_data, out_valid, sel_idx, sel_valid, err_drop, drop_count
    );

endinterface

// File: rtl/route_fifo.sv
// Small power-of-two FIFO with occupancy counter; pushes when full and pops when empty are ignored.
module route_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         CLK,
    input  logic         _RESET,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

    // NOTE: storage is not reset; emptiness gates the output to zero instead.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/decoder_node_n.sv
// Routes each accepted flit to one of NUM_OUT buffered outputs and logs the choice as a select token.
module decoder_node_n
    import decoder_pkg::*;
#(
    parameter int               WIDTH      = 9,
    parameter int               NUM_OUT    = 2,
    parameter route_mode_e      ROUTE_MODE = ROUTE_MASK,
    parameter logic [WIDTH-1:0] MASK       = WIDTH'(9'b000001000),
    parameter int               ROUTE_LSB  = 0,
    parameter int               DEPTH      = 2
) (
    input  logic             CLK,
    input  logic             _RESET,
    decoder_node_n_if.slave  bus
);

    localparam int SEL_W    = sel_width(NUM_OUT);
    localparam int IDX_SPAN = 1 << SEL_W;

    if (ROUTE_MODE == ROUTE_MASK && NUM_OUT != 2) begin : g_bad_mode
        $error("decoder_node_n: mask routing requires NUM_OUT == 2");
    end
    if (NUM_OUT < 2 || NUM_OUT > 16) begin : g_bad_num_out
        $error("decoder_node_n: NUM_OUT must be in 2..16");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("decoder_node_n: DEPTH must be a power of 2 and at least 2");
    end
    if (ROUTE_LSB < 0 || ROUTE_LSB + SEL_W > WIDTH) begin : g_bad_lsb
        $error("decoder_node_n: route field exceeds the flit");
    end

    logic [SEL_W-1:0]                idx_mask;
    logic [SEL_W-1:0]                idx_field;
    logic [SEL_W-1:0]                idx;
    logic                            legal;
    logic [NUM_OUT-1:0]              ch_full;
    logic [NUM_OUT-1:0]              ch_empty;
    logic [NUM_OUT-1:0]              ch_push;
    logic [NUM_OUT-1:0]              ch_pop;
    logic [NUM_OUT-1:0][WIDTH-1:0]   ch_data;
    logic [IDX_SPAN-1:0]             full_span;
    logic                            sel_full;
    logic                            sel_empty;
    logic                            sel_pop;
    logic                            accept;
    logic                            push_ok;
    logic                            drop;
    logic                            err_drop_q;
    logic [DROP_CNT_W-1:0]           drop_cnt_q;

    assign idx_mask  = SEL_W'(|(bus.in_data & MASK));
    assign idx_field = bus.in_data[ROUTE_LSB +: SEL_W];
    assign idx       = (ROUTE_MODE == ROUTE_FIELD) ? idx_field : idx_mask;

    // Only a non-power-of-two channel count leaves route codes without a destination.
    if (NUM_OUT == IDX_SPAN) begin : g_all_legal
        assign legal = 1'b1;
    end else begin : g_range_check
        assign legal = (idx < SEL_W'(NUM_OUT));
    end

    // Full flags come straight from registered occupancy, so ready never depends on a same-cycle pop.
    assign full_span    = IDX_SPAN'(ch_full);
    assign bus.in_ready = !legal || (!full_span[idx] && !sel_full);

    assign accept  = bus.in_valid && bus.in_ready;
    assign push_ok = accept && legal;
    assign drop    = accept && !legal;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        ch_push = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            ch_push[k] = push_ok && (idx == SEL_W'(k));
        end
    end

    assign bus.out_valid = ~ch_empty;
    assign ch_pop        = bus.out_valid & bus.out_ready;
    assign bus.out_data  = ch_data;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_ch
        route_fifo #(
            .W     (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .CLK       (CLK),
            ._RESET    (_RESET),
            .push      (ch_push[k]),
            .push_data (bus.in_data),
            .pop       (ch_pop[k]),
            .pop_data  (ch_data[k]),
            .full      (ch_full[k]),
            .empty     (ch_empty[k])
        );
    end

    assign bus.sel_valid = !sel_empty;
    assign sel_pop       = bus.sel_valid && bus.sel_ready;

    route_fifo #(
        .W     (SEL_W),
        .DEPTH (DEPTH)
    ) u_sel_fifo (
        .CLK       (CLK),
        ._RESET    (_RESET),
        .push      (push_ok),
        .push_data (idx),
        .pop       (sel_pop),
        .pop_data  (bus.sel_idx),
        .full      (sel_full),
        .empty     (sel_empty)
    );

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            err_drop_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            err_drop_q <= drop;
            if (drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    assign bus.err_drop   = err_drop_q;
    assign bus.drop_count = drop_cnt_q;

endmodule

// File: tb/tb_decoder_node_n.sv
// Self-checking bench: mask node (2 outputs), field node (4 outputs, random vs queue model), field node (3 outputs, drops).
module tb_decoder_node_n;
    import decoder_pkg::*;

    localparam int DEPTH_B = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    decoder_node_n_if #(.WIDTH(9), .NUM_OUT(2), .SEL_W(1)) if_a ();
    decoder_node_n_if #(.WIDTH(9), .NUM_OUT(4), .SEL_W(2)) if_b ();
    decoder_node_n_if #(.WIDTH(9), .NUM_OUT(3), .SEL_W(2)) if_c ();

    decoder_node_n #(.WIDTH(9), .NUM_OUT(2), .ROUTE_MODE(ROUTE_MASK), .MASK(9'h008),
                     .ROUTE_LSB(0), .DEPTH(2))
        dut_a (.CLK(clk), ._RESET(rst_n), .bus(if_a));
    decoder_node_n #(.WIDTH(9), .NUM_OUT(4), .ROUTE_MODE(ROUTE_FIELD), .MASK(9'h008),
                     .ROUTE_LSB(0), .DEPTH(DEPTH_B))
        dut_b (.CLK(clk), ._RESET(rst_n), .bus(if_b));
    decoder_node_n #(.WIDTH(9), .NUM_OUT(3), .ROUTE_MODE(ROUTE_FIELD), .MASK(9'h008),
                     .ROUTE_LSB(0), .DEPTH(2))
        dut_c (.CLK(clk), ._RESET(rst_n), .bus(if_c));

    typedef struct {
        logic [8:0] data;
        logic [2:0] exp_valid;
        logic       exp_sel_valid;
        logic [1:0] exp_sel;
        logic       exp_err;
    } vec_t;

    typedef logic [8:0] flit_q_t [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [8:0] d, input logic [1:0] ordy, input logic srdy);
        if_a.in_valid  = v;
        if_a.in_data   = d;
        if_a.out_ready = ordy;
        if_a.sel_ready = srdy;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs [7];
        flit_q_t    mq [4];
        logic [1:0] tq [$];
        int         exp_drops;
        int         not_ready;
        logic       rv;
        logic [8:0] rd;
        logic [3:0] rordy;
        logic       rsrdy;
        logic [1:0] ridx;
        logic       exp_rdy;
        logic [3:0] exp_v;

        if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.out_ready = '1; if_a.sel_ready = 1'b1;
        if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.out_ready = '1; if_b.sel_ready = 1'b1;
        if_c.in_valid = 1'b0; if_c.in_data = '0; if_c.out_ready = '1; if_c.sel_ready = 1'b1;

        // Reset state
        #2;
        check("rst_out_valid_a", 64'(if_a.out_valid), 64'(0));
        check("rst_sel_valid_a", 64'(if_a.sel_valid), 64'(0));
        check("rst_out_data_a", 64'(if_a.out_data), 64'(0));
        check("rst_sel_idx_a", 64'(if_a.sel_idx), 64'(0));
        check("rst_err_drop_a", 64'(if_a.err_drop), 64'(0));
        check("rst_drop_count_c", 64'(if_c.drop_count), 64'(0));
        check("rst_out_valid_b", 64'(if_b.out_valid), 64'(0));
        #10 rst_n = 1'b1;
        tick();

        // Mask mode: 0x008 goes to out 1, 0x001 to out 0, tokens 1 then 0
        drive_a(1'b1, 9'h008, 2'b11, 1'b1);
        check("m_ready0", 64'(if_a.in_ready), 64'(1));
        tick();
        check("m_valid0", 64'(if_a.out_valid), 64'(2'b10));
        check("m_data0", 64'(if_a.out_data[17:9]), 64'(9'h008));
        check("m_selv0", 64'(if_a.sel_valid), 64'(1));
        check("m_sel0", 64'(if_a.sel_idx), 64'(1));
        drive_a(1'b1, 9'h001, 2'b11, 1'b1);
        check("m_ready1", 64'(if_a.in_ready), 64'(1));
        tick();
        check("m_valid1", 64'(if_a.out_valid), 64'(2'b01));
        check("m_data1", 64'(if_a.out_data[8:0]), 64'(9'h001));
        check("m_sel1", 64'(if_a.sel_idx), 64'(0));
        drive_a(1'b0, 9'h000, 2'b11, 1'b1);
        tick();
        check("m_idle_valid", 64'(if_a.out_valid), 64'(0));
        check("m_idle_selv", 64'(if_a.sel_valid), 64'(0));

        // Backpressure on out 1 with DEPTH 2; out 0 traffic keeps flowing
        drive_a(1'b1, 9'h008, 2'b01, 1'b1);
        check("bp_ready_1st", 64'(if_a.in_ready), 64'(1));
        tick();
        drive_a(1'b1, 9'h00C, 2'b01, 1'b1);
        check("bp_ready_2nd", 64'(if_a.in_ready), 64'(1));
        check("bp_head_2nd", 64'(if_a.out_data[17:9]), 64'(9'h008));
        tick();
        drive_a(1'b1, 9'h018, 2'b01, 1'b1);
        check("bp_ready_3rd_a", 64'(if_a.in_ready), 64'(0));
        tick();
        check("bp_ready_3rd_b", 64'(if_a.in_ready), 64'(0));
        tick();
        drive_a(1'b1, 9'h001, 2'b01, 1'b1);
        check("bp_ready_out0", 64'(if_a.in_ready), 64'(1));
        tick();
        drive_a(1'b1, 9'h018, 2'b11, 1'b1);
        check("bp_ready_pop_same_cycle", 64'(if_a.in_ready), 64'(0));
        check("bp_valid_both", 64'(if_a.out_valid), 64'(2'b11));
        check("bp_out0_data", 64'(if_a.out_data[8:0]), 64'(9'h001));
        tick();
        check("bp_ready_after_pop", 64'(if_a.in_ready), 64'(1));
        check("bp_valid_after_pop", 64'(if_a.out_valid), 64'(2'b10));
        check("bp_head_after_pop", 64'(if_a.out_data[17:9]), 64'(9'h00C));
        tick();
        drive_a(1'b0, 9'h000, 2'b11, 1'b1);
        check("bp_third_flit", 64'(if_a.out_data[17:9]), 64'(9'h018));
        check("bp_third_sel", 64'(if_a.sel_idx), 64'(1));
        tick();
        check("bp_drained", 64'({if_a.out_valid, if_a.sel_valid}), 64'(0));

        // Full out-0 FIFO with same-cycle pop
        drive_a(1'b1, 9'h001, 2'b00, 1'b1);
        tick();
        drive_a(1'b1, 9'h002, 2'b00, 1'b1);
        check("ff_ready_2nd", 64'(if_a.in_ready), 64'(1));
        tick();
        drive_a(1'b1, 9'h003, 2'b01, 1'b1);
        check("ff_ready_full", 64'(if_a.in_ready), 64'(0));
        check("ff_head0", 64'(if_a.out_data[8:0]), 64'(9'h001));
        tick();
        check("ff_ready_next", 64'(if_a.in_ready), 64'(1));
        check("ff_head1", 64'(if_a.out_data[8:0]), 64'(9'h002));
        tick();
        drive_a(1'b0, 9'h000, 2'b11, 1'b1);
        check("ff_head2", 64'(if_a.out_data[8:0]), 64'(9'h003));
        check("ff_valid2", 64'(if_a.out_valid), 64'(2'b01));
        tick();
        check("ff_drained", 64'(if_a.out_valid), 64'(0));

        // Field mode, 3 outputs: table of legal and illegal route codes
        vecs[0] = '{9'h100, 3'b001, 1'b1, 2'd0, 1'b0};
        vecs[1] = '{9'h0A1, 3'b010, 1'b1, 2'd1, 1'b0};
        vecs[2] = '{9'h1F2, 3'b100, 1'b1, 2'd2, 1'b0};
        vecs[3] = '{9'h003, 3'b000, 1'b0, 2'd0, 1'b1};
        vecs[4] = '{9'h0FF, 3'b000, 1'b0, 2'd0, 1'b1};
        vecs[5] = '{9'h006, 3'b100, 1'b1, 2'd2, 1'b0};
        vecs[6] = '{9'h005, 3'b010, 1'b1, 2'd1, 1'b0};
        exp_drops = 0;
        for (int i = 0; i < 7; i++) begin
            if_c.in_valid = 1'b1;
            if_c.in_data  = vecs[i].data;
            #1;
            check("tbl_ready", 64'(if_c.in_ready), 64'(1));
            tick();
            if (vecs[i].exp_err) exp_drops++;
            check("tbl_out_valid", 64'(if_c.out_valid), 64'(vecs[i].exp_valid));
            check("tbl_sel_valid", 64'(if_c.sel_valid), 64'(vecs[i].exp_sel_valid));
            check("tbl_err_drop", 64'(if_c.err_drop), 64'(vecs[i].exp_err));
            check("tbl_drop_count", 64'(if_c.drop_count), 64'(exp_drops));
            if (vecs[i].exp_sel_valid) begin
                check("tbl_sel_idx", 64'(if_c.sel_idx), 64'(vecs[i].exp_sel));
                check("tbl_out_data", 64'(if_c.out_data[vecs[i].exp_sel*9 +: 9]), 64'(vecs[i].data));
            end
            if_c.in_valid = 1'b0;
            tick();
            check("tbl_err_pulse_end", 64'(if_c.err_drop), 64'(0));
            check("tbl_idle", 64'({if_c.out_valid, if_c.sel_valid}), 64'(0));
        end

        // 260 back-to-back illegal flits saturate the drop counter
        not_ready = 0;
        for (int i = 0; i < 260; i++) begin
            if_c.in_valid = 1'b1;
            if_c.in_data  = 9'($urandom) | 9'h003;
            #1;
            if (!if_c.in_ready) not_ready++;
            tick();
            if (i == 10) check("sat_mid_count", 64'(if_c.drop_count), 64'(exp_drops + 11));
        end
        check("sat_never_stalled", 64'(not_ready), 64'(0));
        check("sat_err_held", 64'(if_c.err_drop), 64'(1));
        check("sat_no_output", 64'({if_c.out_valid, if_c.sel_valid}), 64'(0));
        check("sat_count", 64'(if_c.drop_count), 64'(255));
        if_c.in_valid = 1'b0;
        tick();
        check("sat_err_low", 64'(if_c.err_drop), 64'(0));
        check("sat_count_hold", 64'(if_c.drop_count), 64'(255));

        // Asynchronous reset with two flits and two tokens buffered
        drive_a(1'b1, 9'h001, 2'b00, 1'b0);
        tick();
        drive_a(1'b1, 9'h008, 2'b00, 1'b0);
        tick();
        drive_a(1'b0, 9'h000, 2'b00, 1'b0);
        check("ar_buffered", 64'({if_a.out_valid, if_a.sel_valid}), 64'(3'b111));
        #2 rst_n = 1'b0;
        #1;
        check("ar_valids", 64'({if_a.out_valid, if_a.sel_valid}), 64'(0));
        check("ar_out_data", 64'(if_a.out_data), 64'(0));
        check("ar_drop_count", 64'(if_c.drop_count), 64'(0));
        #2 rst_n = 1'b1;
        tick();
        drive_a(1'b1, 9'h008, 2'b11, 1'b1);
        check("ar_ready", 64'(if_a.in_ready), 64'(1));
        tick();
        drive_a(1'b0, 9'h000, 2'b11, 1'b1);
        check("ar_first_valid", 64'(if_a.out_valid), 64'(2'b10));
        check("ar_first_data", 64'(if_a.out_data[17:9]), 64'(9'h008));
        check("ar_first_sel", 64'({if_a.sel_valid, if_a.sel_idx}), 64'(2'b11));
        tick();
        check("ar_alone", 64'({if_a.out_valid, if_a.sel_valid}), 64'(0));

        // Field mode, 4 outputs: back-to-back stream 0x100..0x103
        for (int i = 0; i < 4; i++) begin
            if_b.in_valid = 1'b1;
            if_b.in_data  = 9'(9'h100 + i);
            #1;
            check("st_ready", 64'(if_b.in_ready), 64'(1));
            tick();
            check("st_valid", 64'(if_b.out_valid), 64'(4'b0001 << i));
            check("st_data", 64'(if_b.out_data[i*9 +: 9]), 64'(9'h100 + i));
            check("st_sel", 64'({if_b.sel_valid, if_b.sel_idx}), 64'(4 + i));
        end
        if_b.in_valid = 1'b0;
        tick();
        check("st_idle", 64'({if_b.out_valid, if_b.sel_valid}), 64'(0));

        // Randomized traffic against per-channel queues and an ordered token queue
        for (int c = 0; c < 400; c++) begin
            rv    = ($urandom_range(0, 3) != 0);
            rd    = 9'($urandom);
            rordy = 4'($urandom);
            rsrdy = ($urandom_range(0, 3) != 0);
            if_b.in_valid  = rv;
            if_b.in_data   = rd;
            if_b.out_ready = rordy;
            if_b.sel_ready = rsrdy;
            #1;
            ridx    = rd[1:0];
            exp_rdy = (mq[ridx].size() < DEPTH_B) && (tq.size() < DEPTH_B);
            for (int k = 0; k < 4; k++) exp_v[k] = (mq[k].size() != 0);
            check("rnd_in_ready", 64'(if_b.in_ready), 64'(exp_rdy));
            check("rnd_out_valid", 64'(if_b.out_valid), 64'(exp_v));
            for (int k = 0; k < 4; k++) begin
                if (exp_v[k]) check("rnd_out_data", 64'(if_b.out_data[k*9 +: 9]), 64'(mq[k][0]));
            end
            check("rnd_sel_valid", 64'(if_b.sel_valid), 64'(tq.size() != 0));
            if (tq.size() != 0) check("rnd_sel_idx", 64'(if_b.sel_idx), 64'(tq[0]));
            for (int k = 0; k < 4; k++) begin
                if (exp_v[k] && rordy[k]) void'(mq[k].pop_front());
            end
            if (tq.size() != 0 && rsrdy) void'(tq.pop_front());
            if (rv && exp_rdy) begin
                mq[ridx].push_back(rd);
                tq.push_back(ridx);
            end
            tick();
        end
        if_b.in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
